spi_word_fifo_acc: RTL and testbench

- Parametrised successor to the fixed 8-byte SPI byte accumulator.
- Sits between the SPI slave byte output and the raytracing controller, all in the 100 MHz domain.
- Packs received bytes into WORD_BYTES-wide words, with selectable byte order and frame resynchronisation.
- Buffers completed words in a first-word-fall-through FIFO with a ready/valid output, and raises an interrupt level for the MCU (ck_a0 path).

---
 rtl/spi_word_fifo_acc.sv | 92 +++++++++
 tb/tb_spi_word_fifo_acc.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_fifo_acc.sv
// SPI byte-to-word packer feeding a first-word-fall-through word FIFO.
// Supports selectable byte order, frame resync, an occupancy IRQ and sticky overflow.
module spi_word_fifo_acc #(
  parameter int WORD_BYTES = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int IRQ_LEVEL  = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic                            clk,
  input  logic                            ck_rst_,
  input  logic                            i_rx_dv,
  input  logic [7:0]                      i_rx_byte,
  input  logic                            i_frame_start,
  output logic [8*WORD_BYTES-1:0]         o_word,
  output logic                            o_word_valid,
  input  logic                            i_word_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_level,
  output logic                            o_irq,
  output logic                            o_overflow,
  input  logic                            i_clear_overflow,
  output logic                            o_partial_drop
);
  localparam int WW = 8 * WORD_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [CW-1:0] cnt, cnt_eff;
  logic [WW-1:0] shreg, sh_eff, byte_w, shifted;
  logic          word_done;

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wp, rp;
  logic          full, empty, pop, push_ok, ovf_set;

  // A frame start restarts the word before any byte arriving in the same cycle.
  always_comb begin
    cnt_eff = i_frame_start ? '0 : cnt;
    sh_eff  = i_frame_start ? '0 : shreg;
    byte_w  = WW'(i_rx_byte);
    if (MSB_FIRST != 0) shifted = (sh_eff << 8) | byte_w;
    else                shifted = (sh_eff >> 8) | (byte_w << (WW - 8));
    word_done = i_rx_dv && (cnt_eff == CW'(WORD_BYTES - 1));
  end

  always_ff @(posedge clk or negedge ck_rst_) begin
    if (!ck_rst_) begin
      cnt            <= '0;
      shreg          <= '0;
      o_partial_drop <= 1'b0;
    end else begin
      o_partial_drop <= i_frame_start && (cnt != '0);
      if (i_rx_dv) begin
        cnt   <= word_done ? '0 : cnt_eff + CW'(1);
        shreg <= word_done ? '0 : shifted;
      end else if (i_frame_start) begin
        cnt   <= '0;
        shreg <= '0;
      end
    end
  end

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop     = !empty && i_word_ready;
  // A pop frees the slot the same edge, so a full FIFO still accepts the push.
  assign push_ok = word_done && (!full || pop);
  assign ovf_set = word_done && full && !pop;

  always_ff @(posedge clk or negedge ck_rst_) begin
    if (!ck_rst_) begin
      wp         <= '0;
      rp         <= '0;
      o_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wp[AW-1:0]] <= shifted;
        wp              <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      if (ovf_set)               o_overflow <= 1'b1;
      else if (i_clear_overflow) o_overflow <= 1'b0;
    end
  end

  assign o_word       = mem[rp[AW-1:0]];
  assign o_word_valid = !empty;
  assign o_level      = LW'(wp - rp);
  assign o_irq        = (o_level >= LW'(IRQ_LEVEL));

endmodule

// File: tb/tb_spi_word_fifo_acc.sv
// Directed bench: MSB-first and LSB-first instances share stimulus; checks packing,
// resync, FIFO ordering/overflow, same-cycle push+pop when full, and async reset.
module tb_spi_word_fifo_acc;
  logic        clk = 1'b0;
  logic        ck_rst_ = 1'b0;
  logic        i_rx_dv = 1'b0;
  logic [7:0]  i_rx_byte = '0;
  logic        i_frame_start = 1'b0;
  logic        i_word_ready = 1'b0;
  logic        i_clear_overflow = 1'b0;

  logic [63:0] o_word, o_word2;
  logic        o_word_valid, o_word_valid2;
  logic [2:0]  o_level, o_level2;
  logic        o_irq, o_irq2, o_overflow, o_overflow2, o_partial_drop, o_partial_drop2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_word_fifo_acc #(.WORD_BYTES(8), .FIFO_DEPTH(4), .IRQ_LEVEL(1), .MSB_FIRST(1)) dut (
    .clk(clk), .ck_rst_(ck_rst_), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
    .i_frame_start(i_frame_start), .o_word(o_word), .o_word_valid(o_word_valid),
    .i_word_ready(i_word_ready), .o_level(o_level), .o_irq(o_irq),
    .o_overflow(o_overflow), .i_clear_overflow(i_clear_overflow),
    .o_partial_drop(o_partial_drop));

  spi_word_fifo_acc #(.WORD_BYTES(8), .FIFO_DEPTH(4), .IRQ_LEVEL(1), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .ck_rst_(ck_rst_), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
    .i_frame_start(i_frame_start), .o_word(o_word2), .o_word_valid(o_word_valid2),
    .i_word_ready(i_word_ready), .o_level(o_level2), .o_irq(o_irq2),
    .o_overflow(o_overflow2), .i_clear_overflow(i_clear_overflow),
    .o_partial_drop(o_partial_drop2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_dv = 1'b1;
    i_rx_byte = b;
    tick();
    i_rx_dv = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] b0);
    for (int i = 0; i < 8; i++) send_byte(b0 + 8'(i));
  endtask

  task automatic pop_one();
    i_word_ready = 1'b1;
    tick();
    i_word_ready = 1'b0;
  endtask

  // Word built from bytes b0, b0+1, ... b0+7 in arrival order.
  function automatic logic [63:0] w_msb(input logic [7:0] b0);
    logic [63:0] w = '0;
    for (int i = 0; i < 8; i++) w = (w << 8) | 64'(b0 + 8'(i));
    return w;
  endfunction

  function automatic logic [63:0] w_lsb(input logic [7:0] b0);
    logic [63:0] w = '0;
    for (int i = 0; i < 8; i++) w = w | (64'(b0 + 8'(i)) << (8 * i));
    return w;
  endfunction

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_valid", 64'(o_word_valid), 64'd0);
    chk("rst_word", o_word, 64'd0);
    chk("rst_level", 64'(o_level), 64'd0);
    chk("rst_irq", 64'(o_irq), 64'd0);
    chk("rst_ovf", 64'(o_overflow), 64'd0);
    chk("rst_pdrop", 64'(o_partial_drop), 64'd0);
    ck_rst_ = 1'b1;
    tick();

    // Basic packing, both byte orders
    for (int i = 1; i <= 7; i++) send_byte(8'(i));
    chk("t1_not_yet_valid", 64'(o_word_valid), 64'd0);
    send_byte(8'h08);
    chk("t1_valid", 64'(o_word_valid), 64'd1);
    chk("t1_word_msb", o_word, 64'h0102030405060708);
    chk("t1_word_lsb", o_word2, 64'h0807060504030201);
    chk("t1_level", 64'(o_level), 64'd1);
    chk("t1_irq", 64'(o_irq), 64'd1);
    pop_one();
    chk("t1_pop_valid", 64'(o_word_valid), 64'd0);
    chk("t1_pop_level", 64'(o_level), 64'd0);
    chk("t1_pop_irq", 64'(o_irq), 64'd0);
    pop_one();
    chk("t1_ready_empty_level", 64'(o_level), 64'd0);

    // Partial word discarded by frame start
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    chk("t2_pdrop_pulse", 64'(o_partial_drop), 64'd1);
    send_byte(8'hA0);
    chk("t2_pdrop_once", 64'(o_partial_drop), 64'd0);
    for (int i = 1; i < 8; i++) send_byte(8'hA0 + 8'(i));
    chk("t2_word", o_word, 64'hA0A1A2A3A4A5A6A7);
    chk("t2_word_lsb", o_word2, 64'hA7A6A5A4A3A2A1A0);
    chk("t2_level", 64'(o_level), 64'd1);
    pop_one();
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    chk("t2_no_pdrop_at_cnt0", 64'(o_partial_drop), 64'd0);

    // Frame start coincident with a byte: that byte becomes byte 0
    send_byte(8'h99); send_byte(8'h98); send_byte(8'h97);
    i_frame_start = 1'b1;
    i_rx_dv = 1'b1;
    i_rx_byte = 8'hB0;
    tick();
    i_frame_start = 1'b0;
    i_rx_dv = 1'b0;
    chk("t3_pdrop", 64'(o_partial_drop), 64'd1);
    for (int i = 1; i < 8; i++) send_byte(8'hB0 + 8'(i));
    chk("t3_word", o_word, w_msb(8'hB0));
    chk("t3_level", 64'(o_level), 64'd1);
    pop_one();

    // Overflow: 5 words into a 4-deep FIFO
    for (int k = 1; k <= 4; k++) send_word(8'(k * 16));
    chk("t4_level_full", 64'(o_level), 64'd4);
    chk("t4_ovf_before", 64'(o_overflow), 64'd0);
    send_word(8'h50);
    chk("t4_level_after", 64'(o_level), 64'd4);
    chk("t4_ovf_set", 64'(o_overflow), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t4_pop_word%0d", k), o_word, w_msb(8'(k * 16)));
      chk($sformatf("t4_pop_word%0d_lsb", k), o_word2, w_lsb(8'(k * 16)));
      pop_one();
    end
    chk("t4_empty", 64'(o_word_valid), 64'd0);
    chk("t4_ovf_sticky", 64'(o_overflow), 64'd1);
    i_clear_overflow = 1'b1;
    tick();
    i_clear_overflow = 1'b0;
    chk("t4_ovf_cleared", 64'(o_overflow), 64'd0);

    // Full FIFO with pop on the completing edge: no overflow
    for (int k = 1; k <= 4; k++) send_word(8'(k * 16));
    chk("t5_level_full", 64'(o_level), 64'd4);
    for (int i = 0; i < 7; i++) send_byte(8'h50 + 8'(i));
    i_word_ready = 1'b1;
    send_byte(8'h57);
    i_word_ready = 1'b0;
    chk("t5_level_kept", 64'(o_level), 64'd4);
    chk("t5_no_ovf", 64'(o_overflow), 64'd0);
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("t5_pop_word%0d", k), o_word, w_msb(8'(k * 16)));
      pop_one();
    end
    chk("t5_level_empty", 64'(o_level), 64'd0);

    // Async reset mid-word with queued words
    send_word(8'h60);
    send_word(8'h70);
    for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i));
    chk("t6_level_pre", 64'(o_level), 64'd2);
    ck_rst_ = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(o_word_valid), 64'd0);
    chk("t6_rst_level", 64'(o_level), 64'd0);
    chk("t6_rst_irq", 64'(o_irq), 64'd0);
    chk("t6_rst_word", o_word, 64'd0);
    #12;
    ck_rst_ = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) send_byte(8'hC0 + 8'(i));
    chk("t6_no_residue_word", 64'(o_word_valid), 64'd0);
    send_byte(8'hC7);
    chk("t6_word", o_word, w_msb(8'hC0));
    chk("t6_word_lsb", o_word2, w_lsb(8'hC0));
    chk("t6_level", 64'(o_level), 64'd1);
    pop_one();
    chk("t6_level_after_pop", 64'(o_level), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
